// File: rtl/inverter_pipe_if.sv
// Streaming bus for inverter_pipe: producer handshake, consumer handshake, mask control and status.
// parity_out is present only when INVERTER_PARITY_EN is defined.
interface inverter_pipe_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int COUNT_WIDTH = 16
);
    logic                   mask_load;
    logic [DATA_WIDTH-1:0]  mask_in;
    logic [DATA_WIDTH-1:0]  data_in;
    logic                   valid_in;
    logic                   ready_out;
    logic [DATA_WIDTH-1:0]  data_out;
    logic                   valid_out;
    logic                   ready_in;
    logic [COUNT_WIDTH-1:0] word_count;
    logic [DATA_WIDTH-1:0]  mask_out;
`ifdef INVERTER_PARITY_EN
    logic                   parity_out;
`endif

    modport slave (
        input  mask_load, mask_in, data_in, valid_in, ready_in,
        output ready_out, data_out, valid_out, word_count, mask_out
`ifdef INVERTER_PARITY_EN
        , output parity_out
`endif
    );

    modport master (
        output mask_load, mask_in, data_in, valid_in, ready_in,
        input  ready_out, data_out, valid_out, word_count, mask_out
`ifdef INVERTER_PARITY_EN
        , input parity_out
`endif
    );
endinterface

// File: rtl/inverter_pipe.sv
// XOR-with-mask inverter on a LATENCY-stage valid/ready pipe; optional parity via INVERTER_PARITY_EN.
// Latency: word accepted at edge N is on data_out after edge N+LATENCY-1.
// Backpressure: full, capacity LATENCY words, ready_out is combinational from ready_in.
module inverter_pipe #(
    parameter int DATA_WIDTH  = 32,
    parameter int LATENCY     = 2,
    parameter int COUNT_WIDTH = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    inverter_pipe_if.slave bus
);

    if (LATENCY < 1 || LATENCY > 8) begin : g_bad_latency
        $error("inverter_pipe: LATENCY must be in 1..8");
    end

    logic [LATENCY-1:0]                 vld_q, vld_d;
    logic [LATENCY-1:0][DATA_WIDTH-1:0] dat_q, dat_d;
    logic [LATENCY-1:0]                 ld;
    logic [DATA_WIDTH-1:0]              mask_q, mask_d;
    logic [COUNT_WIDTH-1:0]             cnt_q, cnt_d;
    logic                               out_xfer;

    // A stage can load when the consumer takes a word or any stage at or after it has a hole,
    // because every stage ahead of that hole shifts forward this cycle.
    for (genvar g = 0; g < LATENCY; g++) begin : g_stage
        assign ld[g] = bus.ready_in | ~(&vld_q[LATENCY-1:g]);
        if (g == 0) begin : g_first
            assign vld_d[g] = ld[g] ? bus.valid_in : vld_q[g];
            assign dat_d[g] = (ld[g] && bus.valid_in) ? (bus.data_in ^ mask_q) : dat_q[g];
        end else begin : g_rest
            assign vld_d[g] = ld[g] ? vld_q[g-1] : vld_q[g];
            assign dat_d[g] = (ld[g] && vld_q[g-1]) ? dat_q[g-1] : dat_q[g];
        end
    end

    assign out_xfer = vld_q[LATENCY-1] & bus.ready_in;
    assign mask_d   = bus.mask_load ? bus.mask_in : mask_q;
    assign cnt_d    = (out_xfer && (cnt_q != {COUNT_WIDTH{1'b1}})) ? cnt_q + COUNT_WIDTH'(1) : cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= '0;
            dat_q  <= '0;
            mask_q <= '1;
            cnt_q  <= '0;
        end else begin
            vld_q  <= vld_d;
            dat_q  <= dat_d;
            mask_q <= mask_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bus.ready_out  = ld[0];
    assign bus.data_out   = dat_q[LATENCY-1];
    assign bus.valid_out  = vld_q[LATENCY-1];
    assign bus.word_count = cnt_q;
    assign bus.mask_out   = mask_q;

`ifdef INVERTER_PARITY_EN
    logic par_q, par_d;

    // Tracks the last stage exactly, so it holds whenever data_out holds.
    assign par_d = ^dat_d[LATENCY-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end

    assign bus.parity_out = par_q;
`endif

endmodule

// File: tb/tb_inverter_pipe.sv
// Directed and randomized checks of inverter_pipe against a word-queue reference model.
module tb_inverter_pipe;
    localparam int DW   = 8;
    localparam int LAT  = 2;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    inverter_pipe_if #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) bus ();

    inverter_pipe #(.DATA_WIDTH(DW), .LATENCY(LAT), .COUNT_WIDTH(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: words in flight with their age in edges since acceptance.
    logic [DW-1:0] q_dat[$];
    int            q_age[$];
    logic [DW-1:0] m_mask = '1;
    int            m_cnt  = 0;
    logic [DW-1:0] got[$];
    bit            last_acc;
    int            n_dut_acc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        bit exp_vld;
        exp_vld = 1'b0;
        if (q_dat.size() > 0) begin
            if (q_age[0] >= LAT - 1) exp_vld = 1'b1;
        end
        chk("valid_out", {31'b0, bus.valid_out}, {31'b0, exp_vld});
        chk("ready_out", {31'b0, bus.ready_out},
            {31'b0, (q_dat.size() < LAT) || bus.ready_in});
        if (exp_vld) begin
            chk("data_out", 32'(bus.data_out), 32'(q_dat[0]));
`ifdef INVERTER_PARITY_EN
            chk("parity_out", {31'b0, bus.parity_out}, {31'b0, ^q_dat[0]});
`endif
        end
        chk("word_count", 32'(bus.word_count), 32'(m_cnt));
        chk("mask_out", 32'(bus.mask_out), 32'(m_mask));
    endtask

    task automatic step();
        bit in_x, out_x;
        @(negedge clk);
        check_outputs();
        if (bus.valid_in && bus.ready_out) n_dut_acc++;
        in_x  = bus.valid_in && ((q_dat.size() < LAT) || bus.ready_in);
        out_x = 1'b0;
        if (q_dat.size() > 0) out_x = (q_age[0] >= LAT - 1) && bus.ready_in;
        if (out_x) begin
            got.push_back(bus.data_out);
            void'(q_dat.pop_front());
            void'(q_age.pop_front());
            if (m_cnt < CMAX) m_cnt++;
        end
        foreach (q_age[k]) q_age[k]++;
        if (in_x) begin
            q_dat.push_back(bus.data_in ^ m_mask);
            q_age.push_back(0);
        end
        if (bus.mask_load) m_mask = bus.mask_in;
        last_acc = in_x;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d);
        bus.valid_in = 1'b1;
        bus.data_in  = d;
        for (int k = 0; k < 50; k++) begin
            step();
            if (last_acc) break;
        end
        bus.valid_in = 1'b0;
    endtask

    task automatic drain();
        bus.valid_in = 1'b0;
        for (int k = 0; k < 2 * LAT + 4; k++) step();
    endtask

    task automatic chk_got(input string tag, input logic [DW-1:0] exp_tab[$]);
        chk({tag, "_count"}, 32'(got.size()), 32'(exp_tab.size()));
        for (int k = 0; k < got.size() && k < exp_tab.size(); k++)
            chk(tag, 32'(got[k]), 32'(exp_tab[k]));
    endtask

    initial begin
        logic [DW-1:0] bp_w[4];
        logic [DW-1:0] tab[$];
        int idx;

        bus.mask_load = 1'b0;
        bus.mask_in   = '0;
        bus.data_in   = '0;
        bus.valid_in  = 1'b0;
        bus.ready_in  = 1'b1;

        // Reset defaults
        #12;
        chk("rst_valid_out", {31'b0, bus.valid_out}, 32'h0);
        chk("rst_data_out", 32'(bus.data_out), 32'h00);
        chk("rst_mask_out", 32'(bus.mask_out), 32'hFF);
        chk("rst_word_count", 32'(bus.word_count), 32'h0);
`ifdef INVERTER_PARITY_EN
        chk("rst_parity_out", {31'b0, bus.parity_out}, 32'h0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_ready_out", {31'b0, bus.ready_out}, 32'h1);

        // Basic invert, back-to-back
        got.delete();
        send(8'h55); send(8'h57); send(8'h53); send(8'h5B); send(8'h73);
        drain();
        tab = '{8'hAA, 8'hA8, 8'hAC, 8'hA4, 8'h8C};
        chk_got("basic_out", tab);
        chk("basic_count", 32'(bus.word_count), 32'd5);

        // Mask change on the same edge as an accept
        got.delete();
        bus.valid_in  = 1'b1;
        bus.data_in   = 8'h55;
        bus.mask_load = 1'b1;
        bus.mask_in   = 8'h0F;
        step();
        bus.mask_load = 1'b0;
        send(8'h55);
        drain();
        tab = '{8'hAA, 8'h5A};
        chk_got("mask_out_seq", tab);
        chk("mask_reg", 32'(bus.mask_out), 32'h0F);

        // Backpressure: fill with consumer stalled, then release
        got.delete();
        bp_w = '{8'h11, 8'h22, 8'h33, 8'h44};
        bus.ready_in = 1'b0;
        n_dut_acc = 0;
        idx = 0;
        for (int c = 0; c < 4; c++) begin
            bus.valid_in = 1'b1;
            bus.data_in  = bp_w[idx];
            step();
            if (last_acc) idx++;
        end
        chk("bp_accepted", 32'(n_dut_acc), 32'd2);
        chk("bp_ready_out", {31'b0, bus.ready_out}, 32'h0);
        chk("bp_data_hold", 32'(bus.data_out), 32'h1E);
        bus.ready_in = 1'b1;
        for (int c = 0; c < 10 && idx < 4; c++) begin
            bus.valid_in = 1'b1;
            bus.data_in  = bp_w[idx];
            step();
            if (last_acc) idx++;
        end
        drain();
        tab = '{8'h1E, 8'h2D, 8'h3C, 8'h4B};
        chk_got("bp_out", tab);

        // Counter saturation: 11 delivered so far, 9 more makes 20
        for (int k = 0; k < 9; k++) send(8'($urandom));
        drain();
        chk("count_sat", 32'(bus.word_count), 32'd15);

        // Randomized traffic with stalls and mask reloads
        last_acc = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (!bus.valid_in || last_acc) begin
                bus.valid_in = ($urandom_range(0, 3) != 0);
                bus.data_in  = 8'($urandom);
            end
            bus.ready_in  = ($urandom_range(0, 3) != 0);
            bus.mask_load = ($urandom_range(0, 9) == 0);
            bus.mask_in   = 8'($urandom);
            step();
        end
        bus.mask_load = 1'b0;
        bus.ready_in  = 1'b1;
        drain();

        // Mid-stream reset with two words in flight
        bus.ready_in = 1'b0;
        bus.valid_in = 1'b1;
        bus.data_in  = 8'hA5;
        step();
        bus.data_in  = 8'h3C;
        step();
        bus.valid_in = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid_out", {31'b0, bus.valid_out}, 32'h0);
        chk("midrst_data_out", 32'(bus.data_out), 32'h00);
        chk("midrst_mask_out", 32'(bus.mask_out), 32'hFF);
        chk("midrst_word_count", 32'(bus.word_count), 32'h0);
        q_dat.delete();
        q_age.delete();
        m_mask = '1;
        m_cnt  = 0;
        got.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        bus.ready_in = 1'b1;
        send(8'h01);
        drain();
        tab = '{8'hFE};
        chk_got("midrst_out", tab);
        chk("midrst_count_after", 32'(bus.word_count), 32'd1);
`ifdef INVERTER_PARITY_EN
        chk("midrst_parity", {31'b0, bus.parity_out}, 32'h1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
